unidade_controlo: RTL and testbench

UNIDADE_CONTROLO -- requirements
Module: unidade_controlo

---
 rtl/unidade_controlo.sv | 142 ++++++++++++++
 tb/tb_unidade_controlo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controlo.sv
// unidade_controlo -- tiny accumulator CPU control unit.
//
// Fetches 8-bit instructions from an external ROM (5-bit address), executes
// them against an 8-bit accumulator, and pushes values to an output port
// through a valid/ready handshake.
//
// Ports:
//   clock         rising-edge system clock
//   reset         asynchronous, active-high reset
//   enable        run enable, sampled only while fetching
//   endereco      ROM address (program counter)
//   dado          ROM instruction word for endereco
//   saida         output port register
//   saida_valida  high while an OUT transfer is pending
//   saida_pronta  downstream accepts saida when high with saida_valida
//   acc           accumulator
//   zero          high when acc == 0
//   parado        high once a HALT instruction has executed
module unidade_controlo #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [4:0] endereco,
    input  logic [7:0] dado,
    output logic [7:0] saida,
    output logic       saida_valida,
    input  logic       saida_pronta,
    output logic [7:0] acc,
    output logic       zero,
    output logic       parado
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT_OUT,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADDI = 3'b000,
        OP_LDI  = 3'b001,
        OP_SUBI = 3'b010,
        OP_OUT  = 3'b011,
        OP_ROL  = 3'b100,
        OP_JMP  = 3'b101,
        OP_JZ   = 3'b110,
        OP_HALT = 3'b111
    } op_t;

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] saida_q, saida_d;
    logic       valida_q, valida_d;

    op_t        opcode;
    logic [7:0] imm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            acc_q    <= '0;
            saida_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            saida_q  <= saida_d;
            valida_q <= valida_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        saida_d  = saida_q;
        valida_d = valida_q;
        opcode   = op_t'(ir_q[7:5]);
        imm      = {3'b000, ir_q[4:0]};

        case (state_q)
            FETCH: begin
                if (enable) begin
                    ir_d    = dado;
                    // 5-bit add wraps 31 -> 0 naturally
                    pc_d    = pc_q + 5'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_ADDI: acc_d = acc_q + imm;
                    OP_LDI:  acc_d = imm;
                    OP_SUBI: acc_d = acc_q - imm;
                    OP_OUT: begin
                        saida_d  = acc_q;
                        valida_d = 1'b1;
                        state_d  = WAIT_OUT;
                    end
                    OP_ROL:  acc_d = {acc_q[6:0], acc_q[7]};
                    OP_JMP:  pc_d = ir_q[4:0];
                    OP_JZ: begin
                        if (acc_q == 8'd0) begin
                            pc_d = ir_q[4:0];
                        end
                    end
                    OP_HALT: state_d = HALT;
                    default: state_d = FETCH;
                endcase
            end
            WAIT_OUT: begin
                if (saida_pronta) begin
                    valida_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = FETCH;
        endcase
    end

    assign endereco     = pc_q;
    assign saida        = saida_q;
    assign saida_valida = valida_q;
    assign acc          = acc_q;
    assign zero         = (acc_q == 8'd0);
    assign parado       = (state_q == HALT);

endmodule

// File: tb/tb_unidade_controlo.sv
// Self-checking bench for unidade_controlo: a flag-based instruction-level
// model runs alongside the DUT and is compared every cycle, with directed
// programs pinning the model to hand-computed values.
module tb_unidade_controlo;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [4:0] endereco;
    logic [7:0] dado;
    logic [7:0] saida;
    logic       saida_valida;
    logic       saida_pronta;
    logic [7:0] acc;
    logic       zero;
    logic       parado;

    logic [7:0] rom [32];

    int unsigned checks = 0;
    int unsigned errors = 0;

    unidade_controlo #(.RESET_PC(5'd0)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .endereco     (endereco),
        .dado         (dado),
        .saida        (saida),
        .saida_valida (saida_valida),
        .saida_pronta (saida_pronta),
        .acc          (acc),
        .zero         (zero),
        .parado       (parado)
    );

    assign dado = rom[endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] im);
        return {op, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: pc, acc, output port, plus "instruction in flight",
    // "output pending" and "halted" flags.
    logic [4:0] m_pc;
    logic [7:0] m_acc, m_saida, m_ir;
    logic       m_inflight, m_pending, m_halted;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc = 5'd0; m_acc = 8'd0; m_saida = 8'd0; m_ir = 8'd0;
            m_inflight = 1'b0; m_pending = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_pending) begin
            if (saida_pronta) m_pending = 1'b0;
        end else if (m_inflight) begin
            int unsigned imm;
            imm = m_ir % 32;
            m_inflight = 1'b0;
            case (m_ir / 32)
                0: m_acc = 8'((m_acc + imm) % 256);
                1: m_acc = 8'(imm);
                2: m_acc = 8'((m_acc + 256 - imm) % 256);
                3: begin m_saida = m_acc; m_pending = 1'b1; end
                4: m_acc = 8'((m_acc * 2 + m_acc / 128) % 256);
                5: m_pc = 5'(imm);
                6: if (m_acc == 0) m_pc = 5'(imm);
                default: m_halted = 1'b1;
            endcase
        end else if (enable) begin
            m_ir = rom[m_pc];
            m_pc = 5'((m_pc + 1) % 32);
            m_inflight = 1'b1;
        end
    end

    always @(negedge clock) begin
        check("model", {8'd0, endereco, acc, saida, zero, saida_valida, parado},
              {8'd0, m_pc, m_acc, m_saida, (m_acc == 8'd0), m_pending, m_halted});
    end

    // ---------------- helpers ----------------
    task automatic reset_on();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    task automatic reset_off();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_addr(input logic [4:0] a, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (endereco !== a && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {27'd0, endereco}, {27'd0, a});
    endtask

    task automatic wait_valid(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (saida_valida !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, saida_valida}, 32'd1);
    endtask

    task automatic wait_halt(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (parado !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, parado}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned nvalid;
        reset = 1'b0;
        enable = 1'b1;
        saida_pronta = 1'b1;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        #2 reset = 1'b1;
        @(negedge clock);
        check("reset_addr", {27'd0, endereco}, 32'd0);
        check("reset_acc", {24'd0, acc}, 32'd0);
        check("reset_out", {22'd0, saida, saida_valida, parado}, 32'd0);

        // LDI 16, 8x ROL, JMP 11, ADDI 17 @11, JMP 0 @12
        reset_on();
        rom[0] = ins(3'd1, 5'd16);
        for (int i = 1; i <= 8; i++) rom[i] = ins(3'd4, 5'd0);
        rom[9]  = ins(3'd5, 5'd11);
        rom[11] = ins(3'd0, 5'd17);
        rom[12] = ins(3'd5, 5'd0);
        reset_off();
        wait_addr(5'd10, 40, "rol_reach10");
        check("rol_acc16", {24'd0, acc}, 32'd16);
        wait_addr(5'd11, 4, "jmp_to11");
        wait_addr(5'd13, 6, "addi_reach13");
        check("addi_acc33", {24'd0, acc}, 32'd33);
        wait_addr(5'd0, 6, "jmp_to0");
        wait_addr(5'd2, 6, "reload_reach2");
        check("reload_acc16", {24'd0, acc}, 32'd16);

        // LDI 5, SUBI 5, JZ 20, OUT @20 with delayed ready
        reset_on();
        rom[0]  = ins(3'd1, 5'd5);
        rom[1]  = ins(3'd2, 5'd5);
        rom[2]  = ins(3'd6, 5'd20);
        rom[20] = ins(3'd3, 5'd0);
        rom[21] = ins(3'd7, 5'd0);
        saida_pronta = 1'b0;
        reset_off();
        wait_valid(20, "jz_out_valid");
        check("jz_zero", {31'd0, zero}, 32'd1);
        check("jz_addr21", {27'd0, endereco}, 32'd21);
        check("jz_saida0", {24'd0, saida}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            if (saida_valida) nvalid++;
            if (nvalid == 5) saida_pronta = 1'b1;
            @(negedge clock);
        end
        check("out_valid_cycles", nvalid, 32'd5);
        wait_halt(10, "jz_halt");
        check("jz_next_fetch", {27'd0, endereco}, 32'd22);
        saida_pronta = 1'b1;

        // LDI 31 + 9x ADDI 31, OUT -> 310 mod 256 = 0x36
        reset_on();
        rom[0] = ins(3'd1, 5'd31);
        for (int i = 1; i <= 9; i++) rom[i] = ins(3'd0, 5'd31);
        rom[10] = ins(3'd3, 5'd0);
        rom[11] = ins(3'd7, 5'd0);
        reset_off();
        wait_halt(40, "sum_halt");
        check("sum_acc", {24'd0, acc}, 32'h36);
        check("sum_saida", {24'd0, saida}, 32'h36);

        // JZ not taken with acc=1, then run past 31
        reset_on();
        rom[0]  = ins(3'd1, 5'd1);
        rom[1]  = ins(3'd6, 5'd5);
        rom[2]  = ins(3'd5, 5'd30);
        rom[5]  = ins(3'd7, 5'd0);
        reset_off();
        wait_addr(5'd3, 8, "jz_fallthrough");
        wait_addr(5'd31, 4, "reach31");
        wait_addr(5'd0, 4, "wrap_to0");
        check("wrap_acc", {24'd0, acc}, 32'd1);

        // HALT at 3, enable toggling, then reset
        reset_on();
        rom[0] = ins(3'd1, 5'd7);
        rom[3] = ins(3'd7, 5'd0);
        reset_off();
        wait_halt(12, "halt_reached");
        for (int c = 0; c < 10; c++) begin
            enable = ~enable;
            @(negedge clock);
            check("halt_parado", {31'd0, parado}, 32'd1);
            check("halt_addr4", {27'd0, endereco}, 32'd4);
        end
        enable = 1'b1;
        reset_on();
        @(negedge clock);
        check("halt_rst", {18'd0, parado, endereco, acc}, 32'd0);
        reset_off();

        // enable low in FETCH, then reset during WAIT_OUT
        reset_on();
        rom[0] = ins(3'd1, 5'd9);
        rom[1] = ins(3'd3, 5'd0);
        rom[2] = ins(3'd7, 5'd0);
        enable = 1'b0;
        reset_off();
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("idle_state", {19'd0, endereco, acc}, 32'd0);
        end
        enable = 1'b1;
        saida_pronta = 1'b0;
        wait_valid(10, "wait_out_valid");
        check("wait_out_saida", {24'd0, saida}, 32'd9);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, saida_valida}, 32'd0);
        check("async_saida", {24'd0, saida}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        saida_pronta = 1'b1;

        // randomized programs checked cycle by cycle against the model
        for (int p = 0; p < 6; p++) begin
            reset_on();
            for (int i = 0; i < 32; i++) begin
                rom[i] = 8'($urandom);
                if (rom[i][7:5] == 3'b111 && $urandom_range(0, 3) != 0)
                    rom[i][7:5] = 3'b000;
            end
            reset_off();
            for (int c = 0; c < 300; c++) begin
                enable = ($urandom_range(0, 3) != 0);
                saida_pronta = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 149) == 0) begin
                    #3 reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                end
                @(negedge clock);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
